serial_xnor_compare: RTL and testbench
======================================

SERIAL_XNOR_COMPARE -- requirements
Module: serial_xnor_compare

Interface
REQ-001 Parameter FRAME_LEN, default 8, is the number of bit pairs per frame; legal range is 2..255.
REQ-002 Derived constant CNT_W = clog2(FRAME_LEN+1) sets the mismatch-count width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begins a new frame; sampled in IDLE only.
REQ-006 bit_valid  input  1  qualifies a and b in the current cycle.
REQ-007 a  input  1  serial bit, stream A.
REQ-008 b  input  1  serial bit, stream B.
REQ-009 busy  output  1  high while in COMPARE.
REQ-010 done  output  1  one-cycle pulse when frame results become valid.
REQ-011 equal  output  1  high when every bit pair in the last completed frame matched.
REQ-012 mismatches  output  CNT_W  count of unequal bit pairs in the last completed frame.

Function
REQ-013 The FSM SHALL have three states: IDLE, COMPARE and DONE.
REQ-014 IDLE with start=1: next state COMPARE; bit index and running mismatch count cleared to 0.
REQ-015 The per-bit match SHALL be ~(a ^ b), evaluated only in COMPARE with bit_valid=1.
REQ-016 A valid pair with match=0 SHALL increment the running count by 1; no saturation is needed because the maximum count is FRAME_LEN.
REQ-017 bit_valid=0 in COMPARE stalls: no change to the index, the count or the state.
REQ-018 The valid pair with index FRAME_LEN-1: next state DONE; equal and mismatches are registered from the final count (including this bit) on the same edge.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle immediately after the edge that samples the last valid pair.
REQ-021 start=1 in COMPARE SHALL abort the frame: index and count cleared, state stays COMPARE, equal and mismatches unchanged.
REQ-022 start=1 in DONE SHALL be ignored; upstream SHALL wait for busy=0.
REQ-023 bit_valid in IDLE or DONE SHALL be ignored.
REQ-024 equal and mismatches SHALL hold their values until the next DONE entry.
REQ-025 equal SHALL be 1 if and only if the registered mismatches equals 0.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, equal=0, mismatches=0, index=0, count=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first frame after release requires a fresh start.

Configuration
REQ-028 With macro SERIAL_XNOR_MISMATCH_COUNT_EN defined, mismatches SHALL be the full count per REQ-016.
REQ-029 Without the macro, the running counter SHALL be replaced by a sticky 1-bit mismatch flag; mismatches SHALL be tied to 0; equal SHALL still follow REQ-018 and REQ-025 with the same latency.

Structure
REQ-030 Package serial_xnor_pkg SHALL hold the state enum (IDLE, COMPARE, DONE) and default FRAME_LEN.
REQ-031 One sub-module, bit_match_cell (combinational XNOR of a and b gated by bit_valid, output match_valid and match), SHALL be instantiated; all other logic resides in the top module.

Verification (FRAME_LEN=8)
REQ-032 start, then 8 valid pairs a=b=10110010 -> done one cycle after the 8th pair, equal=1, mismatches=0.
REQ-033 start, a=11111111, b=11110000 -> equal=0, mismatches=4; without the macro, equal=0 and mismatches=0.
REQ-034 start, 8 pairs with bit_valid low for 3 cycles after pair 4 -> done exactly one cycle after pair 8; result matches the unstalled case.
REQ-035 start, 5 pairs with 2 mismatches, then start, then 8 matching pairs -> equal=1, mismatches=0; done pulses once only.
REQ-036 rst_n low after pair 6 of a mismatching frame -> all outputs 0 asynchronously; after release, bit_valid without start gives no done for 20 cycles.
REQ-037 start held high in the DONE cycle -> state returns to IDLE; a new frame begins only on a start sampled in IDLE.

Source files
------------

// File: rtl/serial_xnor_pkg.sv
// Shared types and defaults for the serial XNOR frame comparator.
// Build option: SERIAL_XNOR_MISMATCH_COUNT_EN (full mismatch count instead of a 1-bit flag).
package serial_xnor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/bit_match_cell.sv
// Per-pair XNOR cell: match is only asserted for a qualified pair.
module bit_match_cell (
  input  logic bit_valid,
  input  logic a,
  input  logic b,
  output logic match_valid,
  output logic match
);

  assign match_valid = bit_valid;
  assign match       = bit_valid & ~(a ^ b);

endmodule

// File: rtl/serial_xnor_compare.sv
// Compares two serial bit streams over FRAME_LEN qualified pairs and reports equality.
// Build option: SERIAL_XNOR_MISMATCH_COUNT_EN enables the full mismatch count output.
module serial_xnor_compare
  import serial_xnor_pkg::*;
#(
  parameter int  FRAME_LEN = DEFAULT_FRAME_LEN,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] mismatches,
  output state_t           fsm_state
);

  localparam int IDX_W = $clog2(FRAME_LEN);
`ifdef SERIAL_XNOR_MISMATCH_COUNT_EN
  localparam int RUN_W = CNT_W;
`else
  localparam int RUN_W = 1;
`endif

  // Handshake: a and b are consumed on any rising edge where bit_valid=1 and
  // the block is in COMPARE; there is no back-pressure, upstream watches busy.
  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [RUN_W-1:0]   run_q, run_n, run_inc, run_upd;
  logic               equal_q, equal_n;
  logic [CNT_W-1:0]   mism_q, mism_n;
  logic               match_valid, match;
  logic               pair_miss;

  bit_match_cell u_cell (
    .bit_valid   (bit_valid),
    .a           (a),
    .b           (b),
    .match_valid (match_valid),
    .match       (match)
  );

  assign pair_miss = match_valid & ~match;

`ifdef SERIAL_XNOR_MISMATCH_COUNT_EN
  assign run_inc = run_q + RUN_W'(1);
`else
  assign run_inc = 1'b1;
`endif
  assign run_upd = pair_miss ? run_inc : run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      equal_q <= 1'b0;
      mism_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      run_q   <= run_n;
      equal_q <= equal_n;
      mism_q  <= mism_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    run_n   = run_q;
    equal_n = equal_q;
    mism_n  = mism_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = COMPARE;
          idx_n   = '0;
          run_n   = '0;
        end
      end
      COMPARE: begin
        busy = 1'b1;
        // A restart wins over a pair presented in the same cycle.
        if (start) begin
          idx_n = '0;
          run_n = '0;
        end else if (match_valid) begin
          run_n = run_upd;
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_n = DONE;
            equal_n = (run_upd == '0);
`ifdef SERIAL_XNOR_MISMATCH_COUNT_EN
            mism_n  = CNT_W'(run_upd);
`else
            mism_n  = '0;
`endif
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign equal      = equal_q;
  assign mismatches = mism_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_serial_xnor_compare.sv
// Self-checking bench for serial_xnor_compare (FRAME_LEN=8): directed frames plus random traffic.
module tb_serial_xnor_compare;
  import serial_xnor_pkg::*;

  localparam int FL    = 8;
  localparam int CNT_W = $clog2(FL + 1);
`ifdef SERIAL_XNOR_MISMATCH_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             bit_valid = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             busy, done, equal;
  logic [CNT_W-1:0] mismatches;
  state_t           fsm_state;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  serial_xnor_compare #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_valid  (bit_valid),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .mismatches (mismatches),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 waiting for start, 1 collecting pairs, 2 result cycle
  int               phase = 0;
  bit               pairs[$];
  logic             exp_equal = 1'b0;
  logic [CNT_W-1:0] exp_mism = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      pairs.delete();
      exp_equal = 1'b0;
      exp_mism = '0;
    end else begin
      case (phase)
        0: if (start) begin
          phase = 1;
          pairs.delete();
        end
        1: if (start) begin
          pairs.delete();
        end else if (bit_valid) begin
          pairs.push_back(a != b);
          if (pairs.size() == FL) begin
            int cnt;
            cnt = 0;
            foreach (pairs[i]) cnt += int'(pairs[i]);
            exp_equal = (cnt == 0);
            exp_mism = COUNT_EN ? CNT_W'(cnt) : '0;
            phase = 2;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("busy", int'(busy), int'(phase == 1));
      check_val("done", int'(done), int'(phase == 2));
      check_val("equal", int'(equal), int'(exp_equal));
      check_val("mismatches", int'(mismatches), int'(exp_mism));
      if (done) done_count++;
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one cycle; inputs are sampled on the next rising edge.
  task automatic drive(input logic s, input logic v, input logic aa, input logic bb);
    start = s;
    bit_valid = v;
    a = aa;
    b = bb;
    @(posedge clk);
    #2;
    start = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] av, input logic [7:0] bv, input int stall_after);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FL; i++) begin
      drive(1'b0, 1'b1, av[7-i], bv[7-i]);
      if (i + 1 == stall_after)
        repeat (3) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic             ref_equal;
    logic [CNT_W-1:0] ref_mism;
    int               dc;

    #1;
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_equal", int'(equal), 0);
    check_val("reset_mismatches", int'(mismatches), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // identical streams
    run_frame(8'b10110010, 8'b10110010, 0);
    check_val("eq_frame_done", int'(done), 1);
    check_val("eq_frame_equal", int'(equal), 1);
    check_val("eq_frame_mism", int'(mismatches), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // four mismatching pairs
    run_frame(8'b11111111, 8'b11110000, 0);
    check_val("ne_frame_done", int'(done), 1);
    check_val("ne_frame_equal", int'(equal), 0);
    check_val("ne_frame_mism", int'(mismatches), COUNT_EN ? 4 : 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // stall after pair 4 must not change timing after pair 8 nor result
    run_frame(8'b10110010, 8'b10010011, 0);
    ref_equal = equal;
    ref_mism = mismatches;
    check_val("two_miss_mism", int'(ref_mism), COUNT_EN ? 2 : 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'b10110010, 8'b10010011, 4);
    check_val("stall_done", int'(done), 1);
    check_val("stall_equal", int'(equal), int'(ref_equal));
    check_val("stall_mism", int'(mismatches), int'(ref_mism));
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // abort after 5 pairs with 2 mismatches, then a clean frame
    dc = done_count;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, (i < 2) ? 1'b0 : 1'b1);
    check_val("abort_no_done", done_count - dc, 0);
    run_frame(8'b01010101, 8'b01010101, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("abort_equal", int'(equal), 1);
    check_val("abort_mism", int'(mismatches), 0);
    check_val("abort_done_once", done_count - dc, 1);

    // asynchronous reset mid-frame
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_busy", int'(busy), 0);
    check_val("async_done", int'(done), 0);
    check_val("async_equal", int'(equal), 0);
    check_val("async_mism", int'(mismatches), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dc = done_count;
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_val("post_reset_no_done", done_count - dc, 0);
    check_val("post_reset_busy", int'(busy), 0);

    // start held during the result cycle is ignored
    run_frame(8'b00001111, 8'b00001111, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("done_start_ignored", int'(busy), 0);
    dc = done_count;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("done_start_no_frame", done_count - dc, 0);
    run_frame(8'b11001100, 8'b11001101, 0);
    check_val("fresh_frame_done", int'(done), 1);
    check_val("fresh_frame_equal", int'(equal), 0);
    check_val("fresh_frame_mism", int'(mismatches), COUNT_EN ? 1 : 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic aa;
      aa = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 39) == 0) || (!busy && $urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0),
            aa,
            ($urandom_range(0, 9) == 0) ? ~aa : aa);
    end
    check_val("random_frames_seen", int'(done_count > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
